// File: rtl/onehot_decode_seq.sv
// onehot_decode_seq: 4-bit loadable up/down code register with a registered
// 16-bit one-hot decode and a one-cycle wrap pulse.
// Optional feature macro: ONEHOT_DWELL_EN (adds an 8-bit dwell counter so a
// step is taken only every DWELL enabled cycles).
// Bit order: D[0], C[0] are the MSB; Q[i]=1 iff C==i, so Q[0] is the leftmost bit.
module onehot_decode_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OUTS  = 16,
  parameter int unsigned DWELL = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOAD,
  input  logic [0:WIDTH-1] D,
  input  logic             EN,
  input  logic             UP,
  output logic [0:WIDTH-1] C,
  output logic [0:OUTS-1]  Q,
  output logic             WRAP
);

  localparam logic [0:WIDTH-1] CODE_MAX = '1;
  localparam logic [0:WIDTH-1] CODE_MIN = '0;
  localparam logic [0:OUTS-1]  Q_RESET  = OUTS'(1) << (OUTS - 1);

  // Reject parameter sets this revision does not support.
  if (WIDTH != 4 || OUTS != (2 ** WIDTH) || DWELL < 1 || DWELL > 256) begin : g_bad_cfg
    $error("onehot_decode_seq: unsupported WIDTH/OUTS/DWELL combination");
  end

  logic [0:WIDTH-1] code_q, code_d;
  logic [0:OUTS-1]  onehot_q, onehot_d;
  logic             wrap_q, wrap_d;
  logic             step_c;

`ifdef ONEHOT_DWELL_EN
  localparam int unsigned         DCNT_W     = 8;
  localparam logic [DCNT_W-1:0]   DWELL_LAST = DCNT_W'(DWELL - 1);

  logic [DCNT_W-1:0] dwell_q, dwell_d;

  // Dwell pacing: count enabled cycles, qualify a step on the last one; LOAD clears.
  always_comb begin
    dwell_d = dwell_q;
    step_c  = 1'b0;
    if (LOAD) begin
      dwell_d = '0;
    end else if (EN) begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        step_c  = 1'b1;
      end else begin
        dwell_d = dwell_q + DCNT_W'(1);
      end
    end
  end

  // Dwell counter register; EN=0 simply holds the count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end
`else
  // Without pacing, every enabled non-load cycle is a step.
  always_comb begin
    step_c = EN & ~LOAD;
  end
`endif

  // Next code, wrap flag and one-hot decode of the next code (LOAD > step > hold).
  always_comb begin
    code_d   = code_q;
    wrap_d   = 1'b0;
    onehot_d = '0;
    if (LOAD) begin
      code_d = D;
    end else if (step_c) begin
      if (UP) begin
        code_d = code_q + WIDTH'(1);
        wrap_d = (code_q == CODE_MAX);
      end else begin
        code_d = code_q - WIDTH'(1);
        wrap_d = (code_q == CODE_MIN);
      end
    end
    onehot_d[code_d] = 1'b1;
  end

  // Output registers; Q is decoded from code_d so it lands with C.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      code_q   <= '0;
      onehot_q <= Q_RESET;
      wrap_q   <= 1'b0;
    end else begin
      code_q   <= code_d;
      onehot_q <= onehot_d;
      wrap_q   <= wrap_d;
    end
  end

  assign C    = code_q;
  assign Q    = onehot_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_onehot_decode_seq.sv
// Self-checking bench for onehot_decode_seq with directed vectors.
// The dwell scenario uses a second DWELL=3 instance when ONEHOT_DWELL_EN is defined.
`timescale 1ns/1ps
module tb_onehot_decode_seq;

  logic       CLK;
  logic       RST_N;
  logic       LOAD;
  logic [0:3] D;
  logic       EN;
  logic       UP;
  logic [0:3] C;
  logic [0:15] Q;
  logic       WRAP;

  int checks;
  int failures;

  onehot_decode_seq #(.WIDTH(4), .OUTS(16), .DWELL(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .D(D), .EN(EN), .UP(UP),
    .C(C), .Q(Q), .WRAP(WRAP)
  );

`ifdef ONEHOT_DWELL_EN
  logic [0:3]  c3;
  logic [0:15] q3;
  logic        wrap3;
  onehot_decode_seq #(.WIDTH(4), .OUTS(16), .DWELL(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .D(D), .EN(EN), .UP(UP),
    .C(c3), .Q(q3), .WRAP(wrap3)
  );
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected one-hot for code k: Q[k] is bit (15-k) counting from the LSB.
  function automatic logic [0:15] oh(input int k);
    logic [0:15] v;
    v = 16'h8000 >> k;
    return v;
  endfunction

  // 16-to-4 loop-back encoder model; returns 99 if Q is not one-hot.
  function automatic int enc(input logic [0:15] q);
    int idx;
    int n;
    idx = 99;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (q[i]) begin
        idx = i;
        n++;
      end
    end
    if (n != 1) idx = 99;
    return idx;
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; LOAD = 1'b0; EN = 1'b0; UP = 1'b1; D = 4'd0;
    repeat (2) tick();
    checks++;
    if (C !== 4'd0 || Q !== 16'h8000 || WRAP !== 1'b0) begin
      failures++;
      $display("FAIL reset_held: C=%0d Q=%h WRAP=%b, want C=0 Q=8000 WRAP=0", C, Q, WRAP);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (C !== 4'd0 || Q !== 16'h8000 || WRAP !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: C=%0d Q=%h WRAP=%b, want C=0 Q=8000 WRAP=0", i, C, Q, WRAP);
      end
    end
  endtask

  task automatic test_count_up();
    int exp;
    logic expw;
    exp = 0;
    EN = 1'b1; UP = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      exp  = (exp + 1) % 16;
      expw = (exp == 0);
      checks++;
      if (C !== 4'(exp) || Q !== oh(exp) || WRAP !== expw || enc(Q) != exp) begin
        failures++;
        $display("FAIL count_up[%0d]: C=%0d Q=%h WRAP=%b enc=%0d, want C=%0d Q=%h WRAP=%b",
                 i, C, Q, WRAP, enc(Q), exp, oh(exp), expw);
      end
    end
    EN = 1'b0;
  endtask

  task automatic test_count_down();
    LOAD = 1'b1; D = 4'd1; EN = 1'b0;
    tick();
    checks++;
    if (C !== 4'd1 || Q !== oh(1) || WRAP !== 1'b0) begin
      failures++;
      $display("FAIL load_one: C=%0d Q=%h WRAP=%b, want C=1 Q=%h WRAP=0", C, Q, WRAP, oh(1));
    end
    LOAD = 1'b0; EN = 1'b1; UP = 1'b0;
    tick();
    checks++;
    if (C !== 4'd0 || Q !== 16'h8000 || WRAP !== 1'b0) begin
      failures++;
      $display("FAIL down_1to0: C=%0d Q=%h WRAP=%b, want C=0 Q=8000 WRAP=0", C, Q, WRAP);
    end
    tick();
    checks++;
    if (C !== 4'd15 || Q !== 16'h0001 || WRAP !== 1'b1) begin
      failures++;
      $display("FAIL down_0to15: C=%0d Q=%h WRAP=%b, want C=15 Q=0001 WRAP=1", C, Q, WRAP);
    end
    EN = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Starts at C=15: up wraps to 0, then down wraps back to 15 on the next edge.
    EN = 1'b1; UP = 1'b1;
    tick();
    checks++;
    if (C !== 4'd0 || Q !== 16'h8000 || WRAP !== 1'b1) begin
      failures++;
      $display("FAIL b2b_up_wrap: C=%0d Q=%h WRAP=%b, want C=0 Q=8000 WRAP=1", C, Q, WRAP);
    end
    UP = 1'b0;
    tick();
    checks++;
    if (C !== 4'd15 || Q !== 16'h0001 || WRAP !== 1'b1) begin
      failures++;
      $display("FAIL b2b_down_wrap: C=%0d Q=%h WRAP=%b, want C=15 Q=0001 WRAP=1", C, Q, WRAP);
    end
    EN = 1'b0;
    tick();
    checks++;
    if (C !== 4'd15 || WRAP !== 1'b0) begin
      failures++;
      $display("FAIL b2b_hold: C=%0d WRAP=%b, want C=15 WRAP=0", C, WRAP);
    end
  endtask

  task automatic test_load_priority();
    LOAD = 1'b1; D = 4'd3; EN = 1'b0;
    tick();
    checks++;
    if (C !== 4'd3 || Q !== oh(3)) begin
      failures++;
      $display("FAIL load_three: C=%0d Q=%h, want C=3 Q=%h", C, Q, oh(3));
    end
    LOAD = 1'b1; EN = 1'b1; UP = 1'b1; D = 4'd10;
    tick();
    checks++;
    if (C !== 4'd10 || Q !== 16'h0020 || WRAP !== 1'b0) begin
      failures++;
      $display("FAIL load_over_en: C=%0d Q=%h WRAP=%b, want C=10 Q=0020 WRAP=0", C, Q, WRAP);
    end
    // Reload of the same code: nothing visible changes.
    D = 4'd10;
    tick();
    checks++;
    if (C !== 4'd10 || Q !== 16'h0020 || WRAP !== 1'b0) begin
      failures++;
      $display("FAIL load_same: C=%0d Q=%h WRAP=%b, want C=10 Q=0020 WRAP=0", C, Q, WRAP);
    end
    LOAD = 1'b0; EN = 1'b0;
    repeat (2) tick();
    checks++;
    if (C !== 4'd10 || Q !== 16'h0020 || WRAP !== 1'b0) begin
      failures++;
      $display("FAIL hold: C=%0d Q=%h WRAP=%b, want C=10 Q=0020 WRAP=0", C, Q, WRAP);
    end
    // Down step from a mid code, no wrap.
    EN = 1'b1; UP = 1'b0;
    tick();
    checks++;
    if (C !== 4'd9 || Q !== oh(9) || WRAP !== 1'b0) begin
      failures++;
      $display("FAIL down_mid: C=%0d Q=%h WRAP=%b, want C=9 Q=%h WRAP=0", C, Q, WRAP, oh(9));
    end
    EN = 1'b0;
  endtask

  task automatic test_async_reset();
    LOAD = 1'b1; D = 4'd7;
    tick();
    LOAD = 1'b0;
    checks++;
    if (C !== 4'd7 || Q !== oh(7)) begin
      failures++;
      $display("FAIL pre_reset_load: C=%0d Q=%h, want C=7 Q=%h", C, Q, oh(7));
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (C !== 4'd0 || Q !== 16'h8000 || WRAP !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: C=%0d Q=%h WRAP=%b, want C=0 Q=8000 WRAP=0", C, Q, WRAP);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    EN = 1'b1; UP = 1'b1;
    tick();
    checks++;
    if (C !== 4'd1 || Q !== oh(1)) begin
      failures++;
      $display("FAIL post_reset_step: C=%0d Q=%h, want C=1 Q=%h", C, Q, oh(1));
    end
    EN = 1'b0;
  endtask

`ifdef ONEHOT_DWELL_EN
  task automatic test_dwell();
    // EN pattern per cycle (1..11) and expected DWELL=3 code after each cycle.
    logic en_pat [11];
    int   exp_c  [11];
    en_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_c  = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
    LOAD = 1'b1; D = 4'd0; EN = 1'b0; UP = 1'b1;
    tick();
    LOAD = 1'b0;
    for (int i = 0; i < 11; i++) begin
      EN = en_pat[i];
      tick();
      checks++;
      if (c3 !== 4'(exp_c[i]) || q3 !== oh(exp_c[i]) || wrap3 !== 1'b0) begin
        failures++;
        $display("FAIL dwell[cycle %0d]: C=%0d Q=%h WRAP=%b, want C=%0d Q=%h WRAP=0",
                 i + 1, c3, q3, wrap3, exp_c[i], oh(exp_c[i]));
      end
    end
    EN = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_count_up();
    test_count_down();
    test_back_to_back();
    test_load_priority();
    test_async_reset();
`ifdef ONEHOT_DWELL_EN
    test_dwell();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
